// File: rtl/merge_sched_pkg.sv
// Shared types and derived widths for the merge-tree issue controller.
package merge_sched_pkg;

    localparam int unsigned DEF_RID_WIDTH = 4;
    localparam int unsigned DEF_NUM_RID   = 8;
    localparam int unsigned DEF_TAG_WIDTH = 8;
    localparam int unsigned DEF_OUT_DEPTH = 8;

    localparam int unsigned DEF_RIDS_WIDTH = DEF_RID_WIDTH * DEF_NUM_RID;
    localparam int unsigned CREDIT_WIDTH   = $clog2(DEF_OUT_DEPTH + 1);

    // One buffered tree result.
    typedef struct packed {
        logic [DEF_RIDS_WIDTH-1:0] rids;
        logic [DEF_TAG_WIDTH-1:0]  tag;
        logic                      miss;
    } fifo_entry_t;

    function automatic int unsigned rids_width(input int unsigned rid_w, input int unsigned n);
        return rid_w * n;
    endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through synchronous FIFO; push and pop may coincide at any fill level.
module sync_fifo_fwft #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot a full FIFO needs for the push.
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= bump(wr_ptr);
            if (do_pop)  rd_ptr <= bump(rd_ptr);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/merge_tree_scheduler.sv
// Issue controller for the bitonic merge tree: lane join, tag check, credit-gated
// issue, fixed-latency tracking pipe and an output FIFO for downstream backpressure.
module merge_tree_scheduler
    import merge_sched_pkg::*;
#(
    parameter int unsigned M           = 8,
    parameter int unsigned log_M       = 3,
    parameter int unsigned RID_WIDTH   = DEF_RID_WIDTH,
    parameter int unsigned NUM_RID     = DEF_NUM_RID,
    parameter int unsigned log_NUM_RID = 3,
    parameter int unsigned TAG_WIDTH   = DEF_TAG_WIDTH,
    parameter int unsigned TREE_LAT    = 6,
    parameter int unsigned OUT_DEPTH   = DEF_OUT_DEPTH
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [M-1:0]                          lane_valid,
    input  logic [M*rids_width(RID_WIDTH, NUM_RID)-1:0] lane_rids,
    input  logic [M*TAG_WIDTH-1:0]                lane_tag,
    output logic                                  lane_ready,
    output logic [M*rids_width(RID_WIDTH, NUM_RID)-1:0] tree_in,
    input  logic [rids_width(RID_WIDTH, NUM_RID)-1:0]   tree_out,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [rids_width(RID_WIDTH, NUM_RID)-1:0]   out_rids,
    output logic [TAG_WIDTH-1:0]                  out_tag,
    output logic                                  out_miss,
    output logic                                  err_tag
);

    localparam int unsigned RIDS_WIDTH = rids_width(RID_WIDTH, NUM_RID);
    localparam int unsigned CW         = $clog2(OUT_DEPTH + 1);

    if (log_M != $clog2(M) || log_NUM_RID != $clog2(NUM_RID) || OUT_DEPTH < TREE_LAT + 1)
    begin : g_bad_params
        $error("merge_tree_scheduler: inconsistent parameters");
    end

    logic                 all_valid;
    logic                 tags_match;
    logic                 accept;
    logic                 issue;
    logic                 pop;
    logic                 push;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [CW-1:0]        credits;
    logic [TREE_LAT:0]    pipe_valid;
    logic [TAG_WIDTH-1:0] pipe_tag [TREE_LAT+1];
    fifo_entry_t          push_entry;
    fifo_entry_t          head;
    logic [$bits(fifo_entry_t)-1:0] head_bits;

    // Lane join and tag agreement against lane 0.
    always_comb begin
        tags_match = 1'b1;
        for (int unsigned i = 1; i < M; i++) begin
            if (lane_tag[i*TAG_WIDTH +: TAG_WIDTH] != lane_tag[TAG_WIDTH-1:0]) begin
                tags_match = 1'b0;
            end
        end
    end

    assign all_valid  = &lane_valid;
    assign lane_ready = !reset && all_valid && (credits < CW'(OUT_DEPTH));
    assign accept     = lane_ready;
    assign issue      = accept && tags_match;
    assign pop        = out_valid && out_ready;
    assign push       = pipe_valid[TREE_LAT];

    // Tree input register, latency-matched issue pipe, credits and sticky error.
    always_ff @(posedge clk) begin
        if (reset) begin
            tree_in    <= '0;
            pipe_valid <= '0;
            credits    <= '0;
            err_tag    <= 1'b0;
            for (int unsigned i = 0; i <= TREE_LAT; i++) begin
                pipe_tag[i] <= '0;
            end
        end else begin
            if (issue) begin
                tree_in <= lane_rids;
            end
            if (accept && !tags_match) begin
                err_tag <= 1'b1;
            end
            pipe_valid  <= {pipe_valid[TREE_LAT-1:0], issue};
            pipe_tag[0] <= lane_tag[TAG_WIDTH-1:0];
            for (int unsigned i = 1; i <= TREE_LAT; i++) begin
                pipe_tag[i] <= pipe_tag[i-1];
            end
            credits <= credits + CW'(issue) - CW'(pop);
        end
    end

    always_comb begin
        push_entry      = '0;
        push_entry.rids = tree_out;
        push_entry.tag  = pipe_tag[TREE_LAT];
        push_entry.miss = (tree_out == '0);
    end

    sync_fifo_fwft #(
        .WIDTH ($bits(fifo_entry_t)),
        .DEPTH (OUT_DEPTH)
    ) u_out_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (push_entry),
        .dout  (head_bits),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign head      = fifo_entry_t'(head_bits);
    assign out_valid = !fifo_empty;
    assign out_rids  = fifo_empty ? '0 : head.rids;
    assign out_tag   = fifo_empty ? '0 : head.tag;
    assign out_miss  = fifo_empty ? 1'b0 : head.miss;

    // Credits bound in-flight merges to the FIFO depth, so this must never fire.
    overflow_chk: assert property (@(posedge clk) disable iff (reset)
        !(push && fifo_full && !pop));

endmodule
